// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator.
// Each channel accumulates MULT every refclk edge and strobes whenever the
// accumulator reaches DIV, which gives an average strobe rate of refclk*MULT/DIV.
// A lock sequencer keeps every strobe off for LOCK_CYCLES edges after reset
// or after an accepted reconfiguration. It then restarts all accumulators
// from zero on the same edge, so every channel starts in phase.
module frac_clken_gen #(
   parameter  int NUM_CH      = 3,
   parameter  int ACC_W       = 16,
   parameter  int LOCK_CYCLES = 16,
   parameter  int DEF_MULT    = 1,
   parameter  int DEF_DIV     = 2,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_mult,
   input  logic [ACC_W-1:0]  cfg_div,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] clk_en,
   output logic              locked
);

   localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   typedef enum logic {
      S_LOCKING,
      S_LOCKED
   } state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, next_cnt;
   logic             cfg_ok;
   logic             cfg_load;
   logic             cfg_reject;

   logic [ACC_W-1:0] acc    [NUM_CH];
   logic [ACC_W-1:0] mult_r [NUM_CH];
   logic [ACC_W-1:0] div_r  [NUM_CH];
   logic [ACC_W:0]   sum    [NUM_CH];
   logic [NUM_CH-1:0] hit;

   // The config port looks only at the state. There is no combinational path from cfg_valid to cfg_ready.
   assign locked    = (state == S_LOCKED);
   assign cfg_ready = (state == S_LOCKED);

   // Write legality: the channel exists, and 0 < mult <= div (a rate of at most one strobe per cycle).
   assign cfg_ok = (int'(cfg_ch) < NUM_CH) && (cfg_mult != '0) &&
                   (cfg_div != '0) && (cfg_mult <= cfg_div);

   // Next-state, lock counter and handshake decode for the lock sequencer.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the case can infer a latch.
      next_state = state;
      next_cnt   = cnt;
      cfg_load   = 1'b0;
      cfg_reject = 1'b0;
      case (state)
         S_LOCKING: begin
            if (cnt == CNT_LAST) begin
               next_state = S_LOCKED;
               next_cnt   = '0;
            end else begin
               next_cnt = cnt + 1'b1;
            end
         end
         S_LOCKED: begin
            if (cfg_valid) begin
               if (cfg_ok) begin
                  cfg_load   = 1'b1;
                  next_state = S_LOCKING;
                  next_cnt   = '0;
               end else begin
                  cfg_reject = 1'b1;
               end
            end
         end
         default: begin
            next_state = S_LOCKING;
            next_cnt   = '0;
         end
      endcase
   end

   // State register, lock counter and registered error pulse.
   always_ff @(posedge refclk) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      if (!rst_n) begin
         state   <= S_LOCKING;
         cnt     <= '0;
         cfg_err <= 1'b0;
      end else begin
         state   <= next_state;
         cnt     <= next_cnt;
         cfg_err <= cfg_reject;
      end
   end

   // Per-channel accumulator sum. One extra bit holds acc+mult, which can reach 2*div-1 without wrapping.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         sum[i] = {1'b0, acc[i]} + {1'b0, mult_r[i]};
         hit[i] = (sum[i] >= {1'b0, div_r[i]});
      end
   end

   // Per-channel config registers, accumulators and strobes.
   // Accumulators run only while LOCKED and no write is being accepted.
   always_ff @(posedge refclk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!rst_n) begin
            // NOTE: the per-channel config arrays are reset because the outputs depend on known defaults.
            acc[i]    <= '0;
            mult_r[i] <= ACC_W'(DEF_MULT);
            div_r[i]  <= ACC_W'(DEF_DIV);
            clk_en[i] <= 1'b0;
         end else if (state == S_LOCKED && !cfg_load) begin
            acc[i]    <= hit[i] ? ACC_W'(sum[i] - {1'b0, div_r[i]}) : sum[i][ACC_W-1:0];
            clk_en[i] <= hit[i];
         end else begin
            acc[i]    <= '0;
            clk_en[i] <= 1'b0;
            if (cfg_load && int'(cfg_ch) == i) begin
               mult_r[i] <= cfg_mult;
               div_r[i]  <= cfg_div;
            end
         end
      end
   end

endmodule
